// File: rtl/spi_tx_feeder.sv
// Byte FIFO feeding a downstream SPI master through a newd/spi_cs handshake.
// Optional inter-transaction gap enabled by defining SPI_FEEDER_GAP_EN.
module spi_tx_feeder #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  input  logic                       spi_cs,
  output logic                       newd,
  output logic [7:0]                 din,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WLOW  = 3'd2;
  localparam logic [2:0] S_WHIGH = 3'd3;
`ifdef SPI_FEEDER_GAP_EN
  localparam logic [2:0] S_GAP   = 3'd4;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [2:0]    state;
  logic          push;
  logic          pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign busy  = (state != S_IDLE);

  // A pop is only taken from IDLE while the master is deselected.
  assign pop  = (state == S_IDLE) && !empty && spi_cs;
  assign push = wr_en && !full;

  // Storage array; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
      if (wr_en && full) ovf <= 1'b1;
    end
  end

`ifdef SPI_FEEDER_GAP_EN
  logic [7:0] gcnt;

  // Handshake sequencer with post-transaction idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      newd  <= 1'b0;
      din   <= 8'h00;
      gcnt  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            din   <= mem[rptr];
            newd  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!spi_cs) begin
            newd  <= 1'b0;
            state <= S_WLOW;
          end
        end
        S_WLOW:  state <= S_WHIGH;
        S_WHIGH: begin
          if (spi_cs) begin
            gcnt  <= 8'h00;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gcnt == 8'(GAP_CYCLES - 1))
            state <= S_IDLE;
          else
            gcnt <= gcnt + 8'h01;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  logic gap_unused;
  assign gap_unused = |8'(GAP_CYCLES);

  // Handshake sequencer; returns straight to IDLE on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      newd  <= 1'b0;
      din   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            din   <= mem[rptr];
            newd  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!spi_cs) begin
            newd  <= 1'b0;
            state <= S_WLOW;
          end
        end
        S_WLOW:  state <= S_WHIGH;
        S_WHIGH: if (spi_cs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Bench for spi_tx_feeder: queue-based reference model plus directed cases.
// Gap expectations follow SPI_FEEDER_GAP_EN.
module tb_spi_tx_feeder;

  localparam int DEPTH = 8;
`ifdef SPI_FEEDER_GAP_EN
  localparam int GAPN = 4;
`else
  localparam int GAPN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf;
  logic       spi_cs = 1'b1;
  logic       newd;
  logic [7:0] din;
  logic       busy;

  int tests = 0;
  int fails = 0;

  spi_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf),
    .spi_cs(spi_cs), .newd(newd), .din(din), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky overflow and transaction progress.
  logic [7:0] q[$];
  bit         mvalid = 0;
  bit         m_ovf, m_txn, m_req;
  int         m_stage, m_gap;
  logic [7:0] m_din;
  bit         m_idle, m_pop, m_full;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_txn = 0; m_req = 0;
      m_stage = 0; m_gap = 0; m_din = 8'h00;
      mvalid = 1;
    end else if (mvalid) begin
      m_idle = !m_txn && m_gap == 0;
      m_pop  = m_idle && q.size() != 0 && spi_cs;
      m_full = q.size() == DEPTH;
      if (m_txn) begin
        if (m_req) begin
          if (!spi_cs) begin m_req = 0; m_stage = 1; end
        end else if (m_stage == 1) begin
          m_stage = 2;
        end else if (spi_cs) begin
          m_txn = 0; m_gap = GAPN;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end
      if (m_pop) begin
        m_din = q.pop_front();
        m_txn = 1; m_req = 1;
      end
      if (wr_en) begin
        if (m_full) m_ovf = 1;
        else q.push_back(wr_data);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("m_count", int'(count), q.size());
      chk("m_empty", int'(empty), int'(q.size() == 0));
      chk("m_full",  int'(full),  int'(q.size() == DEPTH));
      chk("m_ovf",   int'(ovf),   int'(m_ovf));
      chk("m_newd",  int'(newd),  int'(m_req));
      chk("m_busy",  int'(busy),  int'(m_txn || m_gap > 0));
      chk("m_din",   int'(din),   int'(m_din));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = b[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Act as the SPI master for one byte; leaves spi_cs just raised.
  task automatic hs(output logic [7:0] b);
    int n = 0;
    while (!newd && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!newd) chk("hs_timeout", 0, 1);
    b = din;
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    spi_cs = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  logic [7:0] got[$];
  logic [7:0] b;
  int         n;

  initial begin
    spi_cs = 1'b1;
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_newd",  int'(newd),  0);
    chk("rst_din",   int'(din),   0);
    chk("rst_busy",  int'(busy),  0);

    // Single byte: newd two clocks after the write.
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_newd_early", int'(newd), 0);
    @(negedge clk);
    chk("single_newd", int'(newd), 1);
    chk("single_din", int'(din), 8'hA5);
    spi_cs = 1'b0;
    @(negedge clk);
    chk("single_newd_drop", int'(newd), 0);
    repeat (2) @(negedge clk);
    spi_cs = 1'b1;
    @(negedge clk);
    wait_idle(n);
    chk("single_busy_tail", n, GAPN);
    chk("single_din_hold", int'(din), 8'hA5);

    // Burst in FIFO order.
    do_reset();
    write_bytes('{8'h01, 8'h02, 8'h03});
    chk("burst_count", int'(count), 2);
    got.delete();
    repeat (3) begin
      hs(b);
      got.push_back(b);
    end
    chk("burst_b0", int'(got[0]), 8'h01);
    chk("burst_b1", int'(got[1]), 8'h02);
    chk("burst_b2", int'(got[2]), 8'h03);
    @(negedge clk);
    wait_idle(n);
    chk("burst_empty", int'(empty), 1);

    // Overflow with the first byte stuck in LOAD.
    do_reset();
    write_bytes('{8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
                  8'h15, 8'h16, 8'h17, 8'h18, 8'h19});
    chk("ovf_full",  int'(full),  1);
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag",  int'(ovf),   1);
    chk("ovf_din",   int'(din),   8'h10);
    chk("ovf_newd",  int'(newd),  1);

    // Reset while waiting for spi_cs to rise.
    spi_cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_count", int'(count), 0);
    chk("mid_newd",  int'(newd),  0);
    chk("mid_din",   int'(din),   0);
    chk("mid_ovf",   int'(ovf),   0);
    chk("mid_busy0", int'(busy),  0);
    spi_cs = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_no_newd", int'(newd), 0);
    end

    // Pop and write in the same cycle at count 1.
    do_reset();
    write_bytes('{8'hAA, 8'hBB});
    hs(b);
    chk("pw_first", int'(b), 8'hAA);
    @(negedge clk);
    wait_idle(n);
    chk("pw_count_pre", int'(count), 1);
    wr_en = 1'b1; wr_data = 8'hCC;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pw_count", int'(count), 1);
    chk("pw_newd", int'(newd), 1);
    got.delete();
    repeat (2) begin
      hs(b);
      got.push_back(b);
    end
    chk("pw_b0", int'(got[0]), 8'hBB);
    chk("pw_b1", int'(got[1]), 8'hCC);

    // Spacing from spi_cs rise to the next newd.
    @(negedge clk);
    wait_idle(n);
    do_reset();
    write_bytes('{8'h11, 8'h22});
    hs(b);
    n = 0;
    while (!newd && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("gap_spacing", n, GAPN + 2);
    chk("gap_din", int'(din), 8'h22);
    hs(b);
    @(negedge clk);
    wait_idle(n);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
